// File: rtl/sigmoid_lut_pipe_if.sv
// Valid/ready bus between the gate accumulator, the sigmoid pipe and the gate multiplier.
interface sigmoid_lut_pipe_if #(
  parameter int unsigned INPUT_WIDTH = 12,
  parameter int unsigned OUT_WIDTH   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INPUT_WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sigmoid_lut_pipe.sv
// Three-stage sigmoid evaluator: |x| -> clamped LUT address, synchronous ROM read,
// then reflection 1 - sigmoid(|x|) for negative inputs. Global stall on output backpressure.
module sigmoid_lut_pipe #(
  parameter int unsigned INPUT_WIDTH = 12,
  parameter int unsigned FRAC_BITS   = 6,
  parameter int unsigned LUT_SIZE    = 384,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned OUT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  sigmoid_lut_pipe_if.slave   bus
);

  localparam int unsigned MAG_WIDTH = INPUT_WIDTH - 1;
  localparam int unsigned FIX       = 56;
  localparam logic [OUT_WIDTH:0] ONE_Q = (OUT_WIDTH + 1)'(1) << (OUT_WIDTH - 1);

  // Elaboration-time table entry: round(sigmoid(k / 2^FRAC_BITS) * 2^(OUT_WIDTH-1)),
  // using fixed-point exp(-k/2^FRAC_BITS) built from a series and binary exponentiation.
  function automatic logic [OUT_WIDTH-1:0] sig_entry(input int unsigned k);
    logic [127:0] one, term, step, pw, e, den, q;
    one  = 128'(1) << FIX;
    term = one;
    step = one;
    for (int unsigned n = 1; n < 16; n++) begin
      term = term / 128'(n << FRAC_BITS);
      step = n[0] ? (step - term) : (step + term);
    end
    e  = one;
    pw = step;
    for (int unsigned b = 0; b < 16; b++) begin
      if (k[b]) e = (e * pw) >> FIX;
      pw = (pw * pw) >> FIX;
    end
    den = one + e;
    q   = ((128'(1) << (FIX + OUT_WIDTH - 1)) + (den >> 1)) / den;
    return OUT_WIDTH'(q);
  endfunction

  logic [OUT_WIDTH-1:0] rom_table [LUT_SIZE];

  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
    localparam logic [OUT_WIDTH-1:0] ENTRY = sig_entry(32'(g));
    assign rom_table[g] = ENTRY;
  end

  logic                  v0, v1, v2;
  logic                  s0_sign, s0_sat;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic                  s1_sign, s1_sat;
  logic [OUT_WIDTH-1:0]  rom_q;
  logic [OUT_WIDTH-1:0]  out_q;
  logic                  sat_q;

  logic                  stall;
  logic [MAG_WIDTH-1:0]  mag;
  logic                  mag_sat;
  logic [ADDR_WIDTH-1:0] addr_c;

  // Address clamp: magnitudes at or beyond the table end read the last entry.
  always_comb begin
    stall   = v2 & ~bus.out_ready;
    mag     = bus.in_data[MAG_WIDTH-1:0];
    mag_sat = (mag >= MAG_WIDTH'(LUT_SIZE));
    addr_c  = mag_sat ? ADDR_WIDTH'(LUT_SIZE - 1) : mag[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      s0_sign <= 1'b0;
      s0_sat  <= 1'b0;
      s0_addr <= '0;
      s1_sign <= 1'b0;
      s1_sat  <= 1'b0;
      rom_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else if (!stall) begin
      v0 <= bus.in_valid;
      v1 <= v0;
      v2 <= v1;
      if (bus.in_valid) begin
        s0_sign <= bus.in_data[INPUT_WIDTH-1];
        s0_sat  <= mag_sat;
        s0_addr <= addr_c;
      end
      if (v0) begin
        rom_q   <= rom_table[s0_addr];
        s1_sign <= s0_sign;
        s1_sat  <= s0_sat;
      end
      // rom never exceeds 1.0, so the 17-bit subtraction cannot wrap
      if (v1) begin
        out_q <= s1_sign ? OUT_WIDTH'(ONE_Q - {1'b0, rom_q}) : rom_q;
        sat_q <= s1_sat;
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v2;
  assign bus.out_data  = out_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_sigmoid_lut_pipe.sv
// Bench for sigmoid_lut_pipe: scoreboard fed at input acceptance, drained at output acceptance.
module tb_sigmoid_lut_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sigmoid_lut_pipe_if #(.INPUT_WIDTH(12), .OUT_WIDTH(16)) bus ();

  sigmoid_lut_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  bit          sweep_done;
  logic [15:0] model_rom [384];
  logic [16:0] exp_q [$];

  function automatic logic [16:0] model(input logic [11:0] d);
    logic [10:0] mag;
    logic [15:0] r;
    logic        sat;
    mag = d[10:0];
    sat = (mag >= 11'd384);
    r   = model_rom[sat ? 383 : int'(mag)];
    if (d[11]) r = 16'(17'h08000 - {1'b0, r});
    return {sat, r};
  endfunction

  task automatic run_monitor();
    logic        prev_stall;
    logic [16:0] prev_out, got, expv;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        got = {bus.out_sat, bus.out_data};
        if (prev_stall && bus.out_valid) begin
          n_checks++;
          if (got !== prev_out) begin
            n_fail++;
            $display("FAIL stall_hold: output %h changed while stalled, required %h", got, prev_out);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          n_checks++;
          n_out++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: got %h with no word pending, required none", got);
          end else begin
            expv = exp_q.pop_front();
            if (got !== expv) begin
              n_fail++;
              $display("FAIL scoreboard: {sat,data} %h, required %h", got, expv);
            end
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = got;
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data));
      end
    end
  endtask

  task automatic put(input logic [11:0] d);
    bit ok;
    ok          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL put_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b, required 0", bus.out_valid); end
    if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: %h, required 0000", bus.out_data); end
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: %b, required 0", bus.out_sat); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: %b, required 1", bus.in_ready); end
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: %b, required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: %b, required 0", bus.out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    put(12'h000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early: out_valid %b at slot %0d, required 0", bus.out_valid, c); end
    end
    @(negedge clk);
    n_checks += 3;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_latency: out_valid %b, required 1", bus.out_valid); end
    if (bus.out_data !== 16'h4000) begin n_fail++; $display("FAIL zero_data: %h, required 4000", bus.out_data); end
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL zero_sat: %b, required 0", bus.out_sat); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_symmetry();
    logic [15:0] vals [2];
    int          cnt, first_i, last_i;
    cnt = 0; first_i = -1; last_i = -1;
    vals[0] = '0; vals[1] = '0;
    put(12'h040);
    put(12'h840);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (cnt < 2) vals[cnt] = bus.out_data;
        if (first_i < 0) first_i = c;
        last_i = c;
        cnt++;
      end
    end
    n_checks += 4;
    if (cnt != 2) begin n_fail++; $display("FAIL sym_count: out_valid high %0d cycles, required 2", cnt); end
    if (last_i - first_i != 1) begin n_fail++; $display("FAIL sym_consecutive: gap %0d, required 1", last_i - first_i); end
    if (vals[0] !== model_rom[64]) begin n_fail++; $display("FAIL sym_pos: %h, required %h", vals[0], model_rom[64]); end
    if (17'(vals[0]) + 17'(vals[1]) !== 17'h08000) begin
      n_fail++;
      $display("FAIL sym_neg: %h + %h = %h, required 08000", vals[0], vals[1], 17'(vals[0]) + 17'(vals[1]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    logic [11:0] s_in  [4];
    logic [15:0] s_dat [4];
    logic        s_sat [4];
    bit          ok;
    s_in  = '{12'h1C0, 12'h9C0, 12'h17F, 12'h800};
    s_dat = '{16'h7FAE, 16'h0052, 16'h7FAE, 16'h4000};
    s_sat = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      put(s_in[i]);
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          ok = 1'b1;
          break;
        end
      end
      n_checks += 3;
      if (!ok) begin n_fail++; $display("FAIL sat_timeout[%h]: out_valid 0, required 1", s_in[i]); end
      if (bus.out_data !== s_dat[i]) begin n_fail++; $display("FAIL sat_data[%h]: %h, required %h", s_in[i], bus.out_data, s_dat[i]); end
      if (bus.out_sat !== s_sat[i]) begin n_fail++; $display("FAIL sat_flag[%h]: %b, required %b", s_in[i], bus.out_sat, s_sat[i]); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bp_in [6];
    int          n0;
    bp_in = '{12'h010, 12'h123, 12'h8A5, 12'h2FF, 12'h97F, 12'h001};
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) put(bp_in[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_checks++;
          if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: %b, required 0", k, bus.in_ready); end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    n_checks += 2;
    if (n_out - n0 != 6) begin n_fail++; $display("FAIL bp_count: %0d results, required 6", n_out - n0); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_pending: %0d words left, required 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    int stale;
    put(12'h0C5);
    put(12'h9A0);
    put(12'h255);
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: %b, required 0", bus.out_valid); end
    if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_data: %h, required 0000", bus.out_data); end
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sat: %b, required 0", bus.out_sat); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: %b, required 1", bus.in_ready); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL mid_rst_stale: %0d stale results, required 0", stale); end
    @(posedge clk);
    #1;
    put(12'h0C0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_early: out_valid %b, required 0", bus.out_valid); end
    @(negedge clk);
    n_checks += 2;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_latency: out_valid %b, required 1", bus.out_valid); end
    if (bus.out_data !== model_rom[192]) begin n_fail++; $display("FAIL mid_rst_data_after: %h, required %h", bus.out_data, model_rom[192]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    int n0;
    n0 = n_out;
    sweep_done = 1'b0;
    fork
      begin
        for (int code = 0; code < 4096; code++) begin
          put(12'(code));
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_pending: %0d words left, required 0", exp_q.size()); end
    if (n_out - n0 != 4096) begin n_fail++; $display("FAIL sweep_count: %0d results, required 4096", n_out - n0); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 384; k++) begin
      real r;
      r = 32768.0 / (1.0 + $exp(-real'(k) / 64.0));
      model_rom[k] = 16'($rtoi(r + 0.5));
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fork
      run_monitor();
    join_none
    test_reset();
    test_zero();
    test_symmetry();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
